// File: rtl/dpi_mem_arb_pkg.sv
// Shared types and widths for the DPI memory arbiter.
//   state_e : transaction sequencer states
//   owner_e : which requester owns the transaction in flight
package dpi_mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_e;

endpackage

// File: rtl/dpi_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   en          : grant allowed this cycle
//   ifu_valid   : IFU request pending
//   lsu_valid   : LSU request pending
//   last_grant  : owner of the previous accepted transaction
//   grant       : one-hot grant, bit 0 = IFU, bit 1 = LSU
module rr_arb2
    import dpi_mem_arb_pkg::*;
(
    input  logic       en,
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  owner_e     last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (en) begin
            if (ifu_valid && lsu_valid) begin
                // On a tie the requester that did not go last wins.
                grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
            end else begin
                grant = {lsu_valid, ifu_valid};
            end
        end
    end

endmodule

// File: rtl/dpi_mem_arbiter.sv
// dpi_mem_arbiter: shares one DPI memory port between the IFU (read-only)
// and the LSU (read/write). One transaction at a time: accept, optional
// LATENCY wait cycles, a single memory access cycle, then a registered
// response held until the owner's resp_ready.
//   clock, reset_n        : clock, asynchronous active-low reset
//   ifu_req_*/ifu_resp_*  : IFU request / response valid-ready channels
//   lsu_req_*/lsu_resp_*  : LSU request / response valid-ready channels
//   mem_*                 : DPI memory port (rdata combinational from raddr)
module dpi_mem_arbiter
    import dpi_mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_resp_data,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_wen,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_resp_data,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask
);

    state_e            state_q,    state_d;
    owner_e            owner_q,    owner_d;
    owner_e            last_q,     last_d;
    logic              wen_q,      wen_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [MASK_W-1:0] wmask_q,    wmask_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [DATA_W-1:0] ifu_data_q, ifu_data_d;
    logic [DATA_W-1:0] lsu_data_q, lsu_data_d;

    logic [1:0]        grant;
    logic [DATA_W-1:0] access_data;

    // Gating with reset_n keeps both ready outputs low while reset is held.
    rr_arb2 u_rr_arb2 (
        .en         (reset_n && (state_q == IDLE)),
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    assign ifu_req_ready = grant[0];
    assign lsu_req_ready = grant[1];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        cnt_d      = cnt_q;
        ifu_data_d = ifu_data_q;
        lsu_data_d = lsu_data_q;
        access_data = wen_q ? '0 : mem_rdata;

        case (state_q)
            IDLE: begin
                if (grant[0]) begin
                    owner_d = OWN_IFU;
                    wen_d   = 1'b0;
                    addr_d  = ifu_req_addr;
                    wdata_d = '0;
                    wmask_d = '0;
                end else if (grant[1]) begin
                    owner_d = OWN_LSU;
                    wen_d   = lsu_req_wen;
                    addr_d  = lsu_req_addr;
                    wdata_d = lsu_req_wdata;
                    wmask_d = lsu_req_wmask;
                end
                if (|grant) begin
                    last_d  = owner_d;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = (LATENCY > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (owner_q == OWN_IFU) begin
                    ifu_data_d = access_data;
                end else begin
                    lsu_data_d = access_data;
                end
                state_d = RESP;
            end
            RESP: begin
                if ((owner_q == OWN_IFU && ifu_resp_ready) ||
                    (owner_q == OWN_LSU && lsu_resp_ready)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IFU;
            last_q     <= OWN_LSU;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cnt_q      <= '0;
            ifu_data_q <= '0;
            lsu_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            cnt_q      <= cnt_d;
            ifu_data_q <= ifu_data_d;
            lsu_data_q <= lsu_data_d;
        end
    end

    // Memory strobes decode straight from state flops, so the async reset
    // drops them immediately; a zero-mask write issues no strobe at all.
    assign mem_ren   = (state_q == ACCESS) && !wen_q;
    assign mem_wen   = (state_q == ACCESS) && wen_q && (|wmask_q);
    assign mem_raddr = mem_ren ? addr_q  : '0;
    assign mem_waddr = mem_wen ? addr_q  : '0;
    assign mem_wdata = mem_wen ? wdata_q : '0;
    assign mem_wmask = mem_wen ? wmask_q : '0;

    assign ifu_resp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign lsu_resp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign ifu_resp_data  = ifu_data_q;
    assign lsu_resp_data  = lsu_data_q;

endmodule

// File: doc/dpi_mem_arbiter.md
Name: dpi_mem_arbiter

Overview:
- Shares the single DPI memory port between two requesters: the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Accepts valid/ready requests and grants them round-robin.
- Sequences exactly one memory access per transaction, with a programmable delay before the access.
- Returns a registered response over a valid/ready channel. Sits between the core front/back end and the DPI memory model.

Parameters:
- LATENCY, 0: extra wait cycles between request accept and memory access.
- CNT_W, 8: latency counter width. LATENCY must be < 2^CNT_W.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU request valid
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  32  IFU read address
- ifu_resp_valid  out  1  IFU response valid
- ifu_resp_ready  in  1  IFU consumes response
- ifu_resp_data  out  32  IFU read data
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_addr  in  32  LSU address
- lsu_req_wdata  in  32  LSU write data
- lsu_req_wmask  in  4  LSU byte write mask
- lsu_resp_valid  out  1  LSU response valid
- lsu_resp_ready  in  1  LSU consumes response
- lsu_resp_data  out  32  LSU read data (0 for writes)
- mem_ren  out  1  memory read enable
- mem_raddr  out  32  memory read address
- mem_rdata  in  32  memory read data, combinational from mem_raddr
- mem_wen  out  1  memory write enable, sampled at posedge
- mem_waddr  out  32  memory write address
- mem_wdata  out  32  memory write data
- mem_wmask  out  4  memory byte mask

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE, last_grant = LSU, counter = 0.
  - All *_valid, *_ready, mem_ren and mem_wen are 0.
  - Latched address/data/mask and both resp_data registers are 0.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - The round-robin pick among asserted req_valid drives only the granted requester's req_ready high (combinational). Loser's ready = 0.
  - Tie: the requester not equal to last_grant wins. After reset the IFU wins the first tie.
  - Single valid: that requester wins regardless of last_grant.
  - On accept (valid && ready): latch owner, wen, addr, wdata and wmask; set last_grant = owner; counter = LATENCY.
  - Next state is WAIT if LATENCY > 0, else ACCESS.
- WAIT: counter decrements each cycle. When counter == 1, next state is ACCESS.
- ACCESS (exactly one cycle):
  - Read: mem_ren = 1, mem_raddr = latched addr; mem_rdata is captured into the owner's resp_data register.
  - Write: mem_wen = 1, mem_waddr/mem_wdata/mem_wmask from the latches; owner resp_data = 0.
  - Write with wmask == 4'b0000: mem_wen stays 0; the transaction still completes.
  - Next state: RESP.
- Outside ACCESS: mem_ren = mem_wen = 0, memory address/data outputs = 0. No spurious DPI reads or writes.
- RESP: owner resp_valid = 1; the other requester's resp_valid = 0. resp_data is held stable until resp_ready. On resp_ready, next state is IDLE.
- No req_ready outside IDLE: a new accept cannot overlap a response handshake, giving a one-cycle bubble.
- Latency: accept at cycle N, memory access at cycle N+1+LATENCY, resp_valid first high at N+2+LATENCY.
- Addresses pass through unmodified; alignment is the requester's responsibility.
- Requests are not dropped: a requester holding valid while not granted keeps it and is served within one transaction (round-robin fairness).
- Reset asserted mid-transaction:
  - Immediate return to IDLE, transaction discarded, no response.
  - mem_wen is deasserted asynchronously, so no write occurs at the next edge.

Decomposition:
- Package dpi_mem_arb_pkg holds:
  - state_e (IDLE, WAIT, ACCESS, RESP)
  - owner_e (OWN_IFU, OWN_LSU)
  - constants ADDR_W = 32, DATA_W = 32, MASK_W = 4
- One sub-module: rr_arb2, a 2-way round-robin grant. Inputs: two valids, last_grant, enable. Output: one-hot grant.

Test Plan:
- IFU only, LATENCY=0, read 0x8000_0000, memory holds 0x0000_0413 -> ifu_req_ready high in IDLE; mem_ren high exactly 1 cycle at N+1; ifu_resp_valid at N+2 with data 0x0000_0413; lsu_resp_valid stays 0.
- LSU write, addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 4'b0011, LATENCY=3 -> mem_wen single pulse at N+4 with identical address/data/mask; lsu_resp_valid at N+5 with data 0; a subsequent read returns 0x????_BEEF.
- Both valid continuously after reset, 4 transactions -> grants IFU, LSU, IFU, LSU; never two owners; each resp_valid goes only to its owner.
- RESP backpressure: hold lsu_resp_ready=0 for 5 cycles -> lsu_resp_valid and data stable; no req_ready either side; IDLE one cycle after ready.
- Write with wmask=4'b0000 -> mem_wen never asserted; lsu_resp_valid still delivered.
- Assert reset_n=0 during WAIT of an LSU write (LATENCY=5) -> all outputs 0 immediately; no mem_wen pulse; after release, first tie goes to the IFU.
